// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and constants for the MEM-stage load/store unit:
//             FSM state encoding, RV32 funct3 access codes, the access-size
//             decode helper and the timeout counter width.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TMO_CNT_W = 16;

    // Size comes from funct3[1:0]; the reserved codes 011/110/111 have
    // bit 1 set and therefore fall into the word bucket.
    function automatic lsu_size_e f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   f3_size = SZ_B;
            2'b01:   f3_size = SZ_H;
            default: f3_size = SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_if
//  Purpose  : Data-memory req/gnt/rvalid bus between the LSU and memory.
//  Ports    : master = LSU side (drives request fields, receives gnt/rvalid/
//             rdata); slave = memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Combinational load extraction: selects the byte / halfword /
//             word addressed within the read word and sign- or zero-extends.
//  Ports    : rdata  - raw 32-bit word from memory
//             offset - byte offset (address bits [1:0])
//             funct3 - RV32 load funct3 (bit 2 = unsigned)
//             result - aligned, extended 32-bit load value
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit_b;
    logic        ext_bit_h;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        ext_bit_b = byte_sel[7]  & ~funct3[2];
        ext_bit_h = half_sel[15] & ~funct3[2];

        case (f3_size(funct3[1:0]))
            SZ_B:    result = {{24{ext_bit_b}}, byte_sel};
            SZ_H:    result = {{16{ext_bit_h}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Purpose  : MEM-stage load/store unit. Generates byte enables and lane-
//             replicated store data, runs the req/gnt/rvalid handshake,
//             extracts load data, stalls the pipeline while an access is
//             outstanding and forces completion on a bus timeout.
//  Ports    : clk, reset (async, active-high)
//             valid_in, mem_read_in, mem_write_in, funct3_in, addr_in,
//             store_data_in            - EX/MEM slot
//             dmem (master modport)    - data-memory bus
//             load_data_out            - to MEM/WB memory-data input
//             stall_out, done_out, bus_err_out, misaligned_out
//  Options  : LSU_MISALIGN_TRAP_EN - trap misaligned half/word accesses
//             without issuing a bus request.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [2:0]            funct3_in,
    input  logic [31:0]           addr_in,
    input  logic [31:0]           store_data_in,
    mem_stage_lsu_if.master       dmem,
    output logic [31:0]           load_data_out,
    output logic                  stall_out,
    output logic                  done_out,
    output logic                  bus_err_out,
    output logic                  misaligned_out
);

    localparam bit TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int TMO_LAST = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMO_CNT_W-1:0] TMO_LAST_CNT = TMO_CNT_W'(TMO_LAST);

    lsu_state_e           state_q,     state_d;
    logic [31:0]          addr_q,      addr_d;
    logic                 we_q,        we_d;
    logic [3:0]           be_q,        be_d;
    logic [31:0]          wdata_q,     wdata_d;
    logic [2:0]           funct3_q,    funct3_d;
    logic [1:0]           off_q,       off_d;
    logic [TMO_CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]          load_data_q, load_data_d;
    logic                 bus_err_q,   bus_err_d;
    logic                 misal_q,     misal_d;

    logic        access;
    logic        is_store;
    lsu_size_e   size_in;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        misal_hit;
    logic        tmo_hit;
    logic [31:0] load_result;

    // Read wins when both read and write are asserted.
    assign access   = valid_in & (mem_read_in | mem_write_in);
    assign is_store = mem_write_in & ~mem_read_in;
    assign size_in  = f3_size(funct3_in[1:0]);

    always_comb begin
        case (size_in)
            SZ_B: begin
                be_new    = 4'b0001 << addr_in[1:0];
                wdata_new = {4{store_data_in[7:0]}};
            end
            SZ_H: begin
                be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data_in[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data_in;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal_hit = ((size_in == SZ_H) &  addr_in[0]) |
                       ((size_in == SZ_W) & (addr_in[1:0] != 2'b00));
`else
    assign misal_hit = 1'b0;
`endif

    assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST_CNT);

    lsu_load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
        misal_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (access) begin
                    addr_d   = {addr_in[31:2], 2'b00};
                    we_d     = is_store;
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    funct3_d = funct3_in;
                    off_d    = addr_in[1:0];
                    if (misal_hit) begin
                        state_d = DONE;
                        misal_d = 1'b1;
                        if (!is_store) begin
                            load_data_d = '0;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A granted store is complete; a granted load still needs
                // its data, so a timeout on the grant cycle still aborts it.
                if (dmem.dmem_gnt && we_q) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end else if (dmem.dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem.dmem_rvalid) begin
                    state_d     = DONE;
                    load_data_d = load_result;
                end else if (tmo_hit) begin
                    state_d     = DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
            misal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
            misal_q     <= misal_d;
        end
    end

    assign dmem.dmem_req   = (state_q == REQ);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign load_data_out  = load_data_q;
    assign done_out       = (state_q == DONE);
    assign bus_err_out    = bus_err_q;
    assign misaligned_out = misal_q;
    // Released in DONE so the pipeline advances on the DONE clock edge.
    assign stall_out      = ((state_q == IDLE) & access) |
                            (state_q == REQ) | (state_q == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Purpose  : Self-checking bench for mem_stage_lsu (TIMEOUT_CYCLES = 8).
//             Directed scenarios plus randomized accesses checked against a
//             behavioural model of the access rules.
//  Options  : LSU_MISALIGN_TRAP_EN - expectations follow the DUT build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [31:0] load_data_out;
    logic        stall_out;
    logic        done_out;
    logic        bus_err_out;
    logic        misaligned_out;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .funct3_in      (funct3_in),
        .addr_in        (addr_in),
        .store_data_in  (store_data_in),
        .dmem           (dmem_bus),
        .load_data_out  (load_data_out),
        .stall_out      (stall_out),
        .done_out       (done_out),
        .bus_err_out    (bus_err_out),
        .misaligned_out (misaligned_out)
    );

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_bytes(f3);
        if (sz == 4) return 0;
        if (sz == 2) return (a % 4 >= 2) ? 2 : 0;
        return int'(a % 4);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int ln;
        sz = size_bytes(f3);
        ln = lane_of(f3, a);
        return 4'(((1 << sz) - 1) << ln);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        int sz;
        sz = size_bytes(f3);
        if (sz == 4) return d;
        v = longint'(d) % (longint'(1) << (8 * sz));
        if (sz == 1) return 32'(v * 32'h0101_0101);
        return 32'(v * 32'h0001_0001);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
        longint v;
        longint span;
        int sz;
        sz = size_bytes(f3);
        if (sz == 4) return w;
        span = longint'(1) << (8 * sz);
        v = (longint'(w) >> (8 * lane_of(f3, a))) % span;
        if (f3 < 3'd4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic bit exp_misal(input logic [2:0] f3, input logic [31:0] a);
        if (!TRAP) return 1'b0;
        if (size_bytes(f3) == 2) return (a % 2) != 0;
        if (size_bytes(f3) == 4) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // ---------------- driver / memory responder ----------------
    // Starts on the next negedge (an IDLE cycle), presents the instruction
    // and plays memory until done_out is seen; returns what was observed.
    task automatic run_access(
        input  logic rd, input logic wr, input logic [2:0] f3,
        input  logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdat,
        input  int gnt_dly, input int rv_dly,
        output int done_cyc, output int stall_cyc, output int req_cyc,
        output logic unstable, output logic [31:0] o_addr, output logic [3:0] o_be,
        output logic [31:0] o_wdata, output logic o_we, output logic [31:0] o_load,
        output logic o_err, output logic o_mis);
        logic waiting;
        int   wcnt;
        logic is_wr;
        is_wr = wr & ~rd;
        done_cyc = -1; stall_cyc = 0; req_cyc = 0; unstable = 1'b0;
        o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0;
        o_load = '0; o_err = 1'b0; o_mis = 1'b0;
        waiting = 1'b0; wcnt = 0;
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
        addr_in = addr; store_data_in = sd; dmem_bus.dmem_rdata = rdat;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                #1;
            end
            if (stall_out) stall_cyc++;
            if (done_out) begin
                done_cyc = cyc;
                o_load = load_data_out;
                o_err  = bus_err_out;
                o_mis  = misaligned_out;
                break;
            end
            dmem_bus.dmem_rvalid = waiting && (rv_dly >= 0) && (wcnt >= rv_dly);
            if (waiting) wcnt++;
            if (dmem_bus.dmem_req) begin
                if (req_cyc == 0) begin
                    o_addr = dmem_bus.dmem_addr; o_be = dmem_bus.dmem_be;
                    o_wdata = dmem_bus.dmem_wdata; o_we = dmem_bus.dmem_we;
                end else if (o_addr !== dmem_bus.dmem_addr || o_be !== dmem_bus.dmem_be ||
                             o_wdata !== dmem_bus.dmem_wdata || o_we !== dmem_bus.dmem_we) begin
                    unstable = 1'b1;
                end
                dmem_bus.dmem_gnt = (req_cyc >= gnt_dly);
                if (dmem_bus.dmem_gnt && !is_wr) waiting = 1'b1;
                req_cyc++;
            end else begin
                dmem_bus.dmem_gnt = 1'b0;
            end
        end
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    endtask

    // observation holders shared by the sequential test tasks
    int          t_done, t_stall, t_req;
    logic        t_unst, t_we, t_err, t_mis;
    logic [31:0] t_addr, t_wdata, t_load;
    logic [3:0]  t_be;

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        funct3_in = '0; addr_in = '0; store_data_in = '0;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_bus_ctrl: got req/we/be %b, want 000000",
                     {dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be});
        end
        n_cmp++;
        if ({dmem_bus.dmem_addr, dmem_bus.dmem_wdata, load_data_out} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h wdata %h load %h, want all 0",
                     dmem_bus.dmem_addr, dmem_bus.dmem_wdata, load_data_out);
        end
        n_cmp++;
        if ({stall_out, done_out, bus_err_out, misaligned_out} !== 4'd0) begin
            n_err++;
            $display("FAIL reset_flags: got stall/done/err/mis %b, want 0000",
                     {stall_out, done_out, bus_err_out, misaligned_out});
        end
        reset = 1'b0;
    endtask

    task automatic test_lb();
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if (t_load !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL lb_data: got %h, want ffffff80", t_load);
        end
        n_cmp++;
        if (t_done !== 3) begin
            n_err++; $display("FAIL lb_done_cycle: got %0d, want 3", t_done);
        end
        n_cmp++;
        if (t_stall !== 3) begin
            n_err++; $display("FAIL lb_stall_cycles: got %0d, want 3", t_stall);
        end
        n_cmp++;
        if (t_addr !== 32'h0000_0100) begin
            n_err++; $display("FAIL lb_addr: got %h, want 00000100", t_addr);
        end
        #1;
        @(negedge clk);
        n_cmp++;
        if (done_out !== 1'b0) begin
            n_err++; $display("FAIL lb_done_width: got done %b one cycle later, want 0", done_out);
        end
    endtask

    task automatic test_reset_in_wait();
        logic done_seen;
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        funct3_in = 3'b010; addr_in = 32'h40; dmem_bus.dmem_rdata = 32'h1357_9BDF;
        @(negedge clk); #1;
        dmem_bus.dmem_gnt = dmem_bus.dmem_req;
        @(negedge clk); #1;
        dmem_bus.dmem_gnt = 1'b0;
        n_cmp++;
        if ({stall_out, dmem_bus.dmem_req} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_wait_pre: got stall/req %b, want 10 (in WAIT)",
                     {stall_out, dmem_bus.dmem_req});
        end
        reset = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_bus.dmem_req, stall_out, done_out, load_data_out} !== 35'd0) begin
            n_err++;
            $display("FAIL rst_wait_outputs: got req %b stall %b done %b load %h, want all 0",
                     dmem_bus.dmem_req, stall_out, done_out, load_data_out);
        end
        @(negedge clk);
        reset = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_bus.dmem_rvalid = 1'b0;
            done_seen = done_seen | done_out | dmem_bus.dmem_req;
        end
        n_cmp++;
        if ({done_seen, load_data_out} !== 33'd0) begin
            n_err++;
            $display("FAIL rst_wait_late_rvalid: got done/req seen %b load %h, want 0/0",
                     done_seen, load_data_out);
        end
    endtask

    task automatic test_sh_gnt_delay();
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 4, 0,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if ({t_addr, t_be, t_wdata, t_we} !== {32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1}) begin
            n_err++;
            $display("FAIL sh_bus: got addr %h be %b wdata %h we %b, want 00000200 1100 abcdabcd 1",
                     t_addr, t_be, t_wdata, t_we);
        end
        n_cmp++;
        if (t_unst !== 1'b0 || t_req !== 5) begin
            n_err++;
            $display("FAIL sh_hold: got unstable %b req_cycles %0d, want 0 and 5", t_unst, t_req);
        end
        n_cmp++;
        if (t_done !== 6) begin
            n_err++; $display("FAIL sh_done_cycle: got %0d, want 6", t_done);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if (t_load !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL tmo_preload: got %h, want deadbeef", t_load);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, 0, -1,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if (t_done !== 9) begin
            n_err++; $display("FAIL tmo_done_cycle: got %0d, want 9", t_done);
        end
        n_cmp++;
        if ({t_err, t_load} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL tmo_result: got bus_err %b load %h, want 1 and 0", t_err, t_load);
        end
        #1;
        @(negedge clk);
        n_cmp++;
        if (bus_err_out !== 1'b0) begin
            n_err++; $display("FAIL tmo_err_width: got bus_err %b next cycle, want 0", bus_err_out);
        end
    endtask

    task automatic test_lhu_misaligned();
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h0, 32'h1234_F00D, 0, 0,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        if (TRAP) begin
            n_cmp++;
            if ({t_req, t_done, t_stall, t_mis, t_load} !== {32'd0, 32'd1, 32'd1, 1'b1, 32'd0}) begin
                n_err++;
                $display("FAIL lhu_trap: got req %0d done %0d stall %0d mis %b load %h, want 0 1 1 1 0",
                         t_req, t_done, t_stall, t_mis, t_load);
            end
        end else begin
            n_cmp++;
            if ({t_addr, t_mis, t_load} !== {32'h100, 1'b0, 32'h0000_F00D}) begin
                n_err++;
                $display("FAIL lhu_noTrap: got addr %h mis %b load %h, want 00000100 0 0000f00d",
                         t_addr, t_mis, t_load);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sw_data;
        logic        noise;
        sw_data = $urandom;
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0300, sw_data, 32'h0, 0, 0,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if ({t_done, t_be, t_wdata} !== {32'd2, 4'b1111, sw_data}) begin
            n_err++;
            $display("FAIL b2b_sw: got done %0d be %b wdata %h, want 2 1111 %h",
                     t_done, t_be, t_wdata, sw_data);
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0305, 32'h0, 32'h00C3_0000 | 32'h0000_9A00, 0, 0,
                   t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                   t_load, t_err, t_mis);
        n_cmp++;
        if ({t_done, t_load} !== {32'd3, 32'h0000_009A}) begin
            n_err++;
            $display("FAIL b2b_lbu: got done %0d load %h, want 3 0000009a", t_done, t_load);
        end
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
        noise = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            noise = noise | stall_out | done_out | dmem_bus.dmem_req;
            @(negedge clk);
        end
        valid_in = 1'b0;
        n_cmp++;
        if (noise !== 1'b0) begin
            n_err++; $display("FAIL b2b_nonmem: got stall/done/req activity %b, want 0", noise);
        end
    endtask

    task automatic test_random();
        logic        rd, wr, is_ld, mis;
        logic [2:0]  f3;
        logic [31:0] a, sd, rdat;
        int          gd, rvd, want_done;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(2, 0))
                0: begin rd = 1'b1; wr = 1'b0; end
                1: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            is_ld = rd;
            f3   = 3'($urandom_range(7, 0));
            a    = $urandom; sd = $urandom; rdat = $urandom;
            gd   = $urandom_range(3, 0);
            rvd  = $urandom_range(2, 0);
            mis  = exp_misal(f3, a);
            run_access(rd, wr, f3, a, sd, rdat, gd, rvd,
                       t_done, t_stall, t_req, t_unst, t_addr, t_be, t_wdata, t_we,
                       t_load, t_err, t_mis);
            if (mis) want_done = 1;
            else if (is_ld) want_done = 3 + gd + rvd;
            else want_done = 2 + gd;
            n_cmp++;
            if (t_done !== want_done || t_stall !== want_done || t_err !== 1'b0 || t_mis !== mis) begin
                n_err++;
                $display("FAIL rnd_timing[%0d]: got done %0d stall %0d err %b mis %b, want done/stall %0d err 0 mis %b",
                         n, t_done, t_stall, t_err, t_mis, want_done, mis);
            end
            if (mis) begin
                n_cmp++;
                if (t_req !== 0 || (is_ld && t_load !== 32'd0)) begin
                    n_err++;
                    $display("FAIL rnd_trap[%0d]: got req %0d load %h, want 0 req, load 0", n, t_req, t_load);
                end
            end else if (is_ld) begin
                n_cmp++;
                if ({t_addr, t_we, t_load} !== {a & 32'hFFFF_FFFC, 1'b0, exp_load(rdat, a, f3)}) begin
                    n_err++;
                    $display("FAIL rnd_load[%0d]: f3 %b addr %h rdata %h: got addr %h we %b load %h, want %h 0 %h",
                             n, f3, a, rdat, t_addr, t_we, t_load, a & 32'hFFFF_FFFC, exp_load(rdat, a, f3));
                end
            end else begin
                n_cmp++;
                if ({t_addr, t_we, t_be, t_wdata, t_unst} !==
                    {a & 32'hFFFF_FFFC, 1'b1, exp_be(f3, a), exp_wdata(f3, sd), 1'b0}) begin
                    n_err++;
                    $display("FAIL rnd_store[%0d]: f3 %b addr %h: got addr %h we %b be %b wdata %h unstable %b, want %h 1 %b %h 0",
                             n, f3, a, t_addr, t_we, t_be, t_wdata, t_unst,
                             a & 32'hFFFF_FFFC, exp_be(f3, a), exp_wdata(f3, sd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_reset_in_wait();
        test_sh_gnt_delay();
        test_timeout();
        test_lhu_misaligned();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
